// File: rtl/elastic_buffer_read_controller.sv
// Read side of the RX elastic buffer in the recovered-to-local clock crossing.
// Advances the binary read pointer, holds the fill level near centre by repeating
// or dropping SKP symbols, and falls back to refilling when the buffer runs dry.
module elastic_buffer_read_controller #(
    parameter int                    ADDRESS_WIDTH  = 4,
    parameter int                    DATA_WIDTH     = 9,
    parameter logic [DATA_WIDTH-1:0] SKP_SYMBOL     = 9'h11C,
    parameter int                    START_LEVEL    = 8,
    parameter int                    LOW_THRESHOLD  = 6,
    parameter int                    HIGH_THRESHOLD = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH:0]   write_pointer_sync,
    input  logic [DATA_WIDTH-1:0]    read_data,
    output logic [ADDRESS_WIDTH:0]   read_pointer,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_valid,
    output logic [ADDRESS_WIDTH:0]   occupancy,
    output logic                     skp_added,
    output logic                     skp_removed,
    output logic                     underflow
);

    localparam int PW = ADDRESS_WIDTH + 1;

    // Thresholds narrowed to pointer width so all level comparisons are same-width.
    localparam logic [PW-1:0] START_LVL = START_LEVEL[PW-1:0];
    localparam logic [PW-1:0] LOW_LVL   = LOW_THRESHOLD[PW-1:0];
    localparam logic [PW-1:0] HIGH_LVL  = HIGH_THRESHOLD[PW-1:0];
    localparam logic [PW-1:0] PTR_ONE   = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
    localparam logic [PW-1:0] PTR_ZERO  = '0;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [PW-1:0]          readPtr_q, readPtr_d;
    logic [DATA_WIDTH-1:0]  dataOut_q, dataOut_d;
    logic                   dataValid_q, dataValid_d;
    logic                   adjusted_q, adjusted_d;
    logic                   skpAdded_q, skpAdded_d;
    logic                   skpRemoved_q, skpRemoved_d;
    logic                   underflow_q, underflow_d;
    logic                   headIsSkp;

    // Fill level is a plain modulo difference, so pointer wrap needs no special case.
    assign occupancy = write_pointer_sync - readPtr_q;
    assign headIsSkp = (read_data == SKP_SYMBOL);

    // Next-state logic: FILL waits for the start level; RUN reads one symbol per cycle,
    // with underflow taking precedence over SKP insert, then SKP delete, then a normal read.
    always_comb begin
        state_d      = state_q;
        readPtr_d    = readPtr_q;
        dataOut_d    = dataOut_q;
        dataValid_d  = 1'b0;
        adjusted_d   = adjusted_q;
        skpAdded_d   = 1'b0;
        skpRemoved_d = 1'b0;
        underflow_d  = 1'b0;
        case (state_q)
            FILL: begin
                if (occupancy >= START_LVL) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (occupancy == PTR_ZERO) begin
                    underflow_d = 1'b1;
                    state_d     = FILL;
                end else if (headIsSkp && !adjusted_q && (occupancy < LOW_LVL)) begin
                    dataOut_d   = read_data;
                    dataValid_d = 1'b1;
                    adjusted_d  = 1'b1;
                    skpAdded_d  = 1'b1;
                end else if (headIsSkp && !adjusted_q && (occupancy > HIGH_LVL)) begin
                    readPtr_d    = readPtr_q + PTR_ONE;
                    adjusted_d   = 1'b1;
                    skpRemoved_d = 1'b1;
                end else begin
                    dataOut_d   = read_data;
                    dataValid_d = 1'b1;
                    readPtr_d   = readPtr_q + PTR_ONE;
                    if (!headIsSkp) begin
                        adjusted_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State and output registers; reset abandons any symbol in flight immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= FILL;
            readPtr_q    <= '0;
            dataOut_q    <= '0;
            dataValid_q  <= 1'b0;
            adjusted_q   <= 1'b0;
            skpAdded_q   <= 1'b0;
            skpRemoved_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            readPtr_q    <= readPtr_d;
            dataOut_q    <= dataOut_d;
            dataValid_q  <= dataValid_d;
            adjusted_q   <= adjusted_d;
            skpAdded_q   <= skpAdded_d;
            skpRemoved_q <= skpRemoved_d;
            underflow_q  <= underflow_d;
        end
    end

    assign read_pointer = readPtr_q;
    assign data_out     = dataOut_q;
    assign data_valid   = dataValid_q;
    assign skp_added    = skpAdded_q;
    assign skp_removed  = skpRemoved_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_elastic_buffer_read_controller.sv
// Bench for the elastic buffer read controller: a behavioural RAM feeds read_data,
// a table drives the fill ramp and steady state, and hand sequences cover SKP insert,
// SKP delete, underflow, pointer wrap and asynchronous reset. Output symbols are
// checked against a queue of expected values pushed as stimulus is applied.
module tb_elastic_buffer_read_controller;

    localparam logic [8:0] SKP = 9'h11C;
    localparam logic [8:0] SYM_A  = 9'h0A1;
    localparam logic [8:0] SYM_B  = 9'h0B2;
    localparam logic [8:0] SYM_C  = 9'h0C3;
    localparam logic [8:0] SYM_D  = 9'h0D4;
    localparam logic [8:0] SYM_D2 = 9'h0E5;
    localparam logic [8:0] SYM_E1 = 9'h0F6;
    localparam logic [8:0] SYM_E2 = 9'h017;

    logic       clock;
    logic       reset;
    logic [4:0] writePointerSync;
    logic [8:0] readData;
    logic [4:0] readPointer;
    logic [8:0] dataOut;
    logic       dataValid;
    logic [4:0] occupancy;
    logic       skpAdded;
    logic       skpRemoved;
    logic       underflow;

    logic [8:0] mem [16];
    logic [8:0] expQ [$];
    logic       sbEnable;
    int         checks;
    int         failures;

    typedef struct {
        logic [4:0] wp;
        logic       hasSym;
        logic [8:0] sym;
        logic [4:0] expRp;
        logic       expValid;
        logic [4:0] expOcc;
    } vec_t;

    vec_t vecs [12];

    elastic_buffer_read_controller dut (
        .clock              (clock),
        .reset              (reset),
        .write_pointer_sync (writePointerSync),
        .read_data          (readData),
        .read_pointer       (readPointer),
        .data_out           (dataOut),
        .data_valid         (dataValid),
        .occupancy          (occupancy),
        .skp_added          (skpAdded),
        .skp_removed        (skpRemoved),
        .underflow          (underflow)
    );

    // Combinational RAM read addressed by the low read-pointer bits.
    assign readData = mem[readPointer[3:0]];

    // Free-running local clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Guards against any unexpected stall of the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // One clock: sample just after the edge, pop the scoreboard on valid output,
    // and confirm the compensation/underflow pulses never overlap.
    task automatic step();
        logic [8:0] exp;
        @(posedge clock);
        #1;
        if (sbEnable && dataValid) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL sb_unexpected actual=%0h required=none", dataOut);
            end else begin
                exp = expQ.pop_front();
                checkOutput("sb_data", int'(dataOut), int'(exp));
            end
        end
        checkOutput("pulse_exclusive", int'(skpAdded) + int'(skpRemoved) + int'(underflow) > 1 ? 1 : 0, 0);
    endtask

    task automatic applyStimulus(input vec_t v);
        writePointerSync = v.wp;
        if (v.hasSym) expQ.push_back(v.sym);
        step();
    endtask

    task automatic checkCycle(input string name, input logic [4:0] rp, input logic valid,
                              input logic add, input logic rem, input logic und);
        checkOutput({name, "_rp"}, int'(readPointer), int'(rp));
        checkOutput({name, "_valid"}, int'(dataValid), int'(valid));
        checkOutput({name, "_added"}, int'(skpAdded), int'(add));
        checkOutput({name, "_removed"}, int'(skpRemoved), int'(rem));
        checkOutput({name, "_underflow"}, int'(underflow), int'(und));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        sbEnable = 1'b1;
        reset    = 1'b0;
        writePointerSync = 5'd0;
        for (int i = 0; i < 16; i++) mem[i] = 9'h040 + 9'(i);
        mem[0]  = SYM_A;  mem[1]  = SYM_B;  mem[2]  = SKP;    mem[3]  = SYM_C;
        mem[4]  = SKP;    mem[5]  = SKP;    mem[6]  = SYM_D;
        mem[7]  = SKP;    mem[8]  = SKP;    mem[9]  = SYM_D2;
        mem[10] = SYM_E1; mem[11] = SYM_E2;

        // Fill ramp: write pointer climbs by one per cycle, nothing read until level 8.
        for (int i = 0; i < 8; i++) vecs[i] = '{5'(i + 1), 1'b0, 9'h000, 5'd0, 1'b0, 5'(i + 1)};
        // Steady state at occupancy 8: A,B,SKP,C pass straight through.
        vecs[8]  = '{5'd8,  1'b1, SYM_A, 5'd1, 1'b1, 5'd7};
        vecs[9]  = '{5'd9,  1'b1, SYM_B, 5'd2, 1'b1, 5'd7};
        vecs[10] = '{5'd10, 1'b1, SKP,   5'd3, 1'b1, 5'd7};
        vecs[11] = '{5'd11, 1'b1, SYM_C, 5'd4, 1'b1, 5'd7};

        step();
        step();
        checkCycle("reset", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_data", int'(dataOut), 0);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            checkCycle($sformatf("vec%0d", i), vecs[i].expRp, vecs[i].expValid, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("vec%0d_occ", i), int'(occupancy), int'(vecs[i].expOcc));
        end

        // SKP insert at occupancy 5: first SKP is repeated, pointer holds once.
        writePointerSync = 5'd9;
        expQ.push_back(SKP);   step(); checkCycle("ins0", 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        expQ.push_back(SKP);   step(); checkCycle("ins1", 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        expQ.push_back(SKP);   step(); checkCycle("ins2", 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        expQ.push_back(SYM_D); step(); checkCycle("ins3", 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);

        // SKP delete at occupancy 12: one SKP dropped, one data_valid gap.
        writePointerSync = 5'd19;
        step(); checkCycle("del0", 5'd8, 1'b0, 1'b0, 1'b1, 1'b0);
        expQ.push_back(SKP);    step(); checkCycle("del1", 5'd9,  1'b1, 1'b0, 1'b0, 1'b0);
        expQ.push_back(SYM_D2); step(); checkCycle("del2", 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);

        // Frozen write pointer: drain two symbols, then underflow back to FILL.
        writePointerSync = 5'd12;
        expQ.push_back(SYM_E1); step(); checkCycle("und0", 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        expQ.push_back(SYM_E2); step(); checkCycle("und1", 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        step(); checkCycle("und2", 5'd12, 1'b0, 1'b0, 1'b0, 1'b1);
        step(); checkCycle("und3", 5'd12, 1'b0, 1'b0, 1'b0, 1'b0);

        // Occupancy 7 is not enough to resume.
        writePointerSync = 5'd19;
        step(); checkCycle("hold0", 5'd12, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); checkCycle("hold1", 5'd12, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("hold_occ", int'(occupancy), 7);

        // Occupancy 8 re-enters RUN with no read on the transition edge.
        for (int i = 0; i < 16; i++) mem[i] = 9'h040 + 9'(i);
        sbEnable = 1'b0;
        writePointerSync = 5'd20;
        step(); checkCycle("rerun", 5'd12, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int r = 12; r < 30; r++) begin
            writePointerSync = 5'(r + 8);
            step();
        end
        checkCycle("pump1", 5'h1E, 1'b1, 1'b0, 1'b0, 1'b0);

        // Pointer wrap: read 1E,1F,00,01 back to back against write pointer 06.
        sbEnable = 1'b1;
        writePointerSync = 5'h06;
        #1;
        checkOutput("wrap_occ", int'(occupancy), 8);
        expQ.push_back(9'h04E); step(); checkCycle("wrap0", 5'h1F, 1'b1, 1'b0, 1'b0, 1'b0);
        expQ.push_back(9'h04F); step(); checkCycle("wrap1", 5'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        expQ.push_back(9'h040); step(); checkCycle("wrap2", 5'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        expQ.push_back(9'h041); step(); checkCycle("wrap3", 5'h02, 1'b1, 1'b0, 1'b0, 1'b0);

        // Advance to read pointer 0B, then hit reset between clock edges.
        sbEnable = 1'b0;
        for (int r = 2; r < 11; r++) begin
            writePointerSync = 5'(r + 8);
            step();
        end
        checkCycle("pump2", 5'h0B, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        checkCycle("areset", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("areset_data", int'(dataOut), 0);
        checkOutput("areset_occ", int'(occupancy), 18);

        // Restart from FILL after reset release.
        writePointerSync = 5'd0;
        step();
        reset = 1'b1;
        sbEnable = 1'b1;
        step(); checkCycle("restart0", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        writePointerSync = 5'd8;
        step(); checkCycle("restart1", 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        expQ.push_back(9'h040);
        step(); checkCycle("restart2", 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        sbEnable = 1'b0;
        checkOutput("sb_drained", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
